// File: rtl/rf_scoreboard.sv
// Register file with 2 read ports, 1 write port, a pending scoreboard and a sequential clear engine.
// Optional macro RF_WRITE_BYPASS_EN enables the same-cycle write-to-read bypass.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_pending,
    output logic              rt_pending,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              clr_req,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                ready_q;
    logic [DEPTH-1:0]    pend_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                idle;
    logic                wr_ok;
    logic                pend_ok;
    logic [DATA_W-1:0]   rs_data_d;
    logic [DATA_W-1:0]   rt_data_d;
    logic                rs_pend_d;
    logic                rt_pend_d;

    // Entry 0 is a constant zero only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle    = (state_q == S_IDLE);
    assign wr_ok   = idle && wr_en    && !is_zero_reg(wr_addr);
    assign pend_ok = idle && pend_set && !is_zero_reg(pend_addr);

    always_comb begin
        rs_data_d = '0;
        rt_data_d = '0;
        rs_pend_d = 1'b0;
        rt_pend_d = 1'b0;
        if (idle && !is_zero_reg(rs_addr)) begin
            rs_data_d = regs_q[rs_addr];
            rs_pend_d = pend_q[rs_addr];
`ifdef RF_WRITE_BYPASS_EN
            if (wr_en && (wr_addr == rs_addr)) begin
                rs_data_d = wr_data;
            end
`endif
        end
        if (idle && !is_zero_reg(rt_addr)) begin
            rt_data_d = regs_q[rt_addr];
            rt_pend_d = pend_q[rt_addr];
`ifdef RF_WRITE_BYPASS_EN
            if (wr_en && (wr_addr == rt_addr)) begin
                rt_data_d = wr_data;
            end
`endif
        end
    end

    assign rs_data    = rs_data_d;
    assign rt_data    = rt_data_d;
    assign rs_pending = rs_pend_d;
    assign rt_pending = rt_pend_d;
    assign ready      = ready_q;

    // Storage is not reset directly; the clear sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            pend_q    <= '0;
            ready_q   <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            regs_q[clr_idx_q] <= '0;
            clr_idx_q         <= clr_idx_q + 1'b1;
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
            end
        end else if (clr_req) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            pend_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
                pend_q[wr_addr] <= 1'b0;
            end
            // A set in the same cycle as a release wins: a new producer has issued.
            if (pend_ok) begin
                pend_q[pend_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed cases with literal expectations plus a random run
// compared every cycle against a behavioural model.
module tb_rf_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs_addr, rt_addr, wr_addr, pend_addr;
    logic [DW-1:0] rs_data, rt_data, wr_data;
    logic          rs_pending, rt_pending;
    logic          wr_en, pend_set, clr_req, ready;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_r [DEPTH];
    logic          m_p [DEPTH];
    int            clear_left;

    rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .clr_req    (clr_req),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (clear_left > 0 || a == 0) return '0;
`ifdef RF_WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_r[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a);
        if (clear_left > 0 || a == 0) return 1'b0;
        return m_p[a];
    endfunction

    task automatic sample();
        @(negedge clk);
        n_vec++;
        chk("ready",      {31'd0, ready},      {31'd0, clear_left == 0});
        chk("rs_data",    rs_data,             exp_data(rs_addr));
        chk("rt_data",    rt_data,             exp_data(rt_addr));
        chk("rs_pending", {31'd0, rs_pending}, {31'd0, exp_pend(rs_addr)});
        chk("rt_pending", {31'd0, rt_pending}, {31'd0, exp_pend(rt_addr)});
    endtask

    // Model: a clear empties the file at once; reads are 0 until the sweep's DEPTH cycles elapse.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_r[i] = '0; m_p[i] = 1'b0; end
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (clr_req) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_r[i] = '0; m_p[i] = 1'b0; end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_r[wr_addr] = wr_data;
                m_p[wr_addr] = 1'b0;
            end
            if (pend_set && pend_addr != 0) m_p[pend_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic quiet();
        rst = 0; wr_en = 0; pend_set = 0; clr_req = 0;
    endtask

    task automatic count_not_ready(input string name);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            sample();
            if (ready) break;
            advance();
            cnt++;
        end
        chk(name, cnt, 32);
        advance();
    endtask

    initial begin
        rst = 1; wr_en = 0; pend_set = 0; clr_req = 0;
        rs_addr = 0; rt_addr = 0; wr_addr = 0; pend_addr = 0; wr_data = 0;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin m_r[i] = '0; m_p[i] = 1'b0; end

        // Reset sweep
        advance();
        cyc();
        rst = 0;
        count_not_ready("reset_sweep_len");
        for (int i = 0; i < DEPTH; i++) begin
            rs_addr = AW'(i); rt_addr = AW'(DEPTH - 1 - i);
            sample();
            chk("sweep_rs_zero", rs_data, 32'h0);
            chk("sweep_rt_pend", {31'd0, rt_pending}, 32'd0);
            advance();
        end

        // Write then read
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        cyc();
        wr_en = 0; rs_addr = 5; rt_addr = 5;
        sample();
        chk("rd_rs_r5", rs_data, 32'hDEADBEEF);
        chk("rd_rt_r5", rt_data, 32'hDEADBEEF);
        advance();

        // Bypass
        wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; rs_addr = 7;
        sample();
`ifdef RF_WRITE_BYPASS_EN
        chk("bypass_same_cycle", rs_data, 32'h12345678);
`else
        chk("no_bypass_old", rs_data, 32'h0);
`endif
        advance();
        wr_en = 0;
        sample();
        chk("bypass_next_cycle", rs_data, 32'h12345678);
        advance();

        // Scoreboard
        pend_set = 1; pend_addr = 9;
        cyc();
        pend_set = 0; rs_addr = 9;
        sample();
        chk("pend_set_r9", {31'd0, rs_pending}, 32'd1);
        advance();
        wr_en = 1; wr_addr = 9; wr_data = 32'hA5;
        sample();
        chk("pend_no_bypass", {31'd0, rs_pending}, 32'd1);
        advance();
        wr_en = 0;
        sample();
        chk("pend_released", {31'd0, rs_pending}, 32'd0);
        advance();
        wr_en = 1; wr_data = 32'h5A; pend_set = 1;
        cyc();
        wr_en = 0; pend_set = 0;
        sample();
        chk("set_wins_data", rs_data, 32'h5A);
        chk("set_wins_pend", {31'd0, rs_pending}, 32'd1);
        advance();

        // Zero register
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; pend_set = 1; pend_addr = 0; rs_addr = 0;
        sample();
        chk("r0_no_bypass", rs_data, 32'h0);
        advance();
        quiet();
        sample();
        chk("r0_reads_zero", rs_data, 32'h0);
        chk("r0_pend_zero", {31'd0, rs_pending}, 32'd0);
        advance();

        // clr_req with a concurrent (discarded) write
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i);
            cyc();
        end
        wr_en = 1; wr_addr = 4; wr_data = 32'h4; clr_req = 1; pend_set = 1; pend_addr = 2;
        cyc();
        quiet();
        count_not_ready("clr_sweep_len");
        for (int i = 1; i <= 4; i++) begin
            rs_addr = AW'(i); rt_addr = 9;
            sample();
            chk("clr_zeroed", rs_data, 32'h0);
            chk("clr_pend", {31'd0, rs_pending | rt_pending}, 32'd0);
            advance();
        end

        // Reset in the middle of a sweep
        clr_req = 1;
        cyc();
        clr_req = 0;
        for (int i = 0; i < 10; i++) cyc();
        rst = 1;
        cyc();
        rst = 0;
        count_not_ready("midsweep_rst_len");

        // Random run against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            clr_req   = ($urandom_range(0, 199) == 0);
            wr_en     = ($urandom_range(0, 1) == 1);
            pend_set  = ($urandom_range(0, 9) < 3);
            wr_addr   = AW'($urandom_range(0, 7));
            pend_addr = AW'($urandom_range(0, 7));
            rs_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            rt_addr   = ($urandom_range(0, 3) == 0) ? pend_addr : AW'($urandom_range(0, DEPTH - 1));
            wr_data   = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
